apb4_master_example: RTL and testbench

APB4_MASTER_EXAMPLE -- requirements
Module: apb4_master_example

---
 rtl/apb4_pkg.sv | 17 +
 rtl/apb4_mst_timer.sv | 40 ++++
 rtl/apb4_master_example.sv | 167 ++++++++++++++++
 tb/tb_apb4_master_example.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_pkg.sv
// Shared definitions for the APB4 master: FSM state encoding, PPROT default
// and default width constants.
package apb4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic [2:0]  PPROT_DEFAULT   = 3'b000;
  localparam int unsigned ADDR_W_DEF      = 12;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/apb4_mst_timer.sv
// ACCESS-phase wait counter for the APB4 master. Only built when
// APB_MST_TIMEOUT_EN is defined; without it this file contributes nothing.
`ifdef APB_MST_TIMEOUT_EN
module apb4_mst_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear on command accept, count ACCESS cycles spent waiting for pready.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/apb4_master_example.sv
// APB4 master: accepts one command at a time, runs a SETUP/ACCESS transfer
// and holds the response until consumed.
// Optional feature: define APB_MST_TIMEOUT_EN to abort ACCESS phases that
// wait TIMEOUT_CYC cycles without pready.
module apb4_master_example
  import apb4_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  output logic [2:0]          pprot,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr,
  output logic                timeout_o
);

  apb_state_e state_q, state_d;

  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] strb_q,  strb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q,   err_d;

`ifdef APB_MST_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic tmr_clr, tmr_inc, tmr_expired;

  assign tmr_clr = (state_q == ST_IDLE) && cmd_valid;
  assign tmr_inc = (state_q == ST_ACCESS) && !pready;

  apb4_mst_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .inc_i    (tmr_inc),
    .expired_o(tmr_expired)
  );

  assign timeout_o = timeout_q;

  // One-cycle abort pulse, visible in the first RESP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout_o = 1'b0;
`endif

  // Next-state, command/response capture and APB control decode.
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
`ifdef APB_MST_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          // Reads never present byte strobes on the bus.
          strb_d  = cmd_write ? cmd_strb : '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        psel    = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          rdata_d = write_q ? '0 : prdata;
          err_d   = pslverr;
          state_d = ST_RESP;
        end
`ifdef APB_MST_TIMEOUT_EN
        else if (tmr_expired) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, command and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign pwrite    = write_q;
  assign paddr     = addr_q;
  assign pwdata    = wdata_q;
  assign pstrb     = strb_q;
  assign pprot     = PPROT_DEFAULT;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb4_master_example.sv
// Self-checking bench for apb4_master_example with a behavioural APB slave
// (16-word RAM at 0x000-0x03C, read-only ID 0x3F at 0xFC4, error elsewhere).
`timescale 1ns/1ps
module tb_apb4_master_example;

`ifdef APB_MST_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        timeout_o;

  always #5 clk = ~clk;

  apb4_master_example #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .timeout_o(timeout_o)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Expected per-cycle view, maintained by the stimulus process.
  bit          chk_en = 1'b0;
  logic        e_cmd_ready, e_psel, e_pen, e_rsp_valid, e_to, e_pwrite, e_err;
  logic [11:0] e_paddr;
  logic [31:0] e_pwdata, e_rdata;
  logic [3:0]  e_pstrb;

  // Slave memory model.
  logic [31:0] mem [16];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(e_cmd_ready));
      chk("psel",      32'(psel),      32'(e_psel));
      chk("penable",   32'(penable),   32'(e_pen));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
      chk("timeout_o", 32'(timeout_o), 32'(e_to));
      chk("pprot",     32'(pprot),     32'd0);
      chk("rsp_rdata", rsp_rdata,      e_rdata);
      chk("rsp_err",   32'(rsp_err),   32'(e_err));
      if (e_psel) begin
        chk("paddr",  32'(paddr),  32'(e_paddr));
        chk("pwrite", 32'(pwrite), 32'(e_pwrite));
        chk("pwdata", pwdata,      e_pwdata);
        chk("pstrb",  32'(pstrb),  32'(e_pstrb));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    cmd_valid = 1'($urandom);
    cmd_write = 1'($urandom);
    cmd_addr  = 12'($urandom);
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
    rsp_ready = 1'($urandom);
  endtask

  task automatic set_idle_exp();
    e_cmd_ready = 1'b1; e_psel = 1'b0; e_pen = 1'b0; e_rsp_valid = 1'b0; e_to = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      rsp_ready = 1'($urandom);
      pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      set_idle_exp();
      cycle();
    end
  endtask

  // Slave response for a completed transfer; applies writes to the memory.
  task automatic slave_resp(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                            input logic [3:0] st, output logic [31:0] rd, output bit er);
    rd = $urandom;
    er = 1'b0;
    if (a[11:6] == 6'd0) begin
      if (wr) begin
        for (int unsigned b = 0; b < 4; b++)
          if (st[b]) mem[a[5:2]][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        rd = mem[a[5:2]];
      end
    end else if (a == 12'hFC4) begin
      if (!wr) rd = 32'h0000_003F;
    end else begin
      er = 1'b1;
    end
  endtask

  // One full transaction, starting in an IDLE cycle (#1 after the edge).
  // w = pready-low ACCESS cycles, d = rsp_ready-low RESP cycles.
  task automatic run_txn(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input int unsigned w, input int unsigned d,
                         output int unsigned lat, output logic [31:0] rd_act, output bit er_act);
    logic [31:0] rd_m;
    bit          er_m;
    bit          to;
    int unsigned n, t;
    to = 1'b0;
`ifdef APB_MST_TIMEOUT_EN
    to = (w >= TMO);
`endif
    n = to ? 32'(TMO_OR_ZERO()) : w + 1;
    rd_m = '0; er_m = 1'b0;
    if (!to) slave_resp(wr, a, wd, st, rd_m, er_m);
    lat = 0; rd_act = '0; er_act = 1'b0; t = 0;
    // accept cycle
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_strb = st;
    rsp_ready = 1'($urandom);
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    set_idle_exp();
    cycle(); t++;
    // SETUP
    noise();
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    e_cmd_ready = 1'b0; e_psel = 1'b1; e_pen = 1'b0;
    e_paddr = a; e_pwrite = wr; e_pwdata = wd; e_pstrb = wr ? st : 4'h0;
    // ACCESS
    for (int unsigned k = 0; k < n; k++) begin
      cycle(); t++;
      if (lat == 0 && rsp_valid) begin lat = t; rd_act = rsp_rdata; er_act = rsp_err; end
      noise();
      e_pen = 1'b1;
      pready = (!to && k == w);
      if (pready) begin prdata = rd_m; pslverr = er_m; end
      else begin prdata = $urandom; pslverr = 1'($urandom); end
    end
    // RESP
    for (int unsigned j = 0; j <= d; j++) begin
      cycle(); t++;
      if (lat == 0 && rsp_valid) begin lat = t; rd_act = rsp_rdata; er_act = rsp_err; end
      noise();
      rsp_ready = (j == d);
      pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      e_psel = 1'b0; e_pen = 1'b0; e_rsp_valid = 1'b1; e_cmd_ready = 1'b0;
      e_to = to && (j == 0);
      if (j == 0) begin
        e_rdata = (wr || to) ? 32'h0 : rd_m;
        e_err   = to ? 1'b1 : er_m;
      end
    end
    cycle();
    cmd_valid = 1'b0;
    rsp_ready = 1'($urandom);
    set_idle_exp();
  endtask

  function automatic int unsigned TMO_OR_ZERO();
`ifdef APB_MST_TIMEOUT_EN
    return TMO;
`else
    return 0;
`endif
  endfunction

  function automatic logic [11:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 6)       return {6'd0, 4'($urandom), 2'b00};
    else if (r == 6) return 12'hFC4;
    else if (r == 7) return 12'h100;
    else             return 12'($urandom) & 12'hFFC;
  endfunction

  int unsigned lat;
  logic [31:0] rd;
  bit          er;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    e_rdata = '0; e_err = 1'b0; e_paddr = '0; e_pwrite = 1'b0; e_pwdata = '0; e_pstrb = '0;
    set_idle_exp();
    #2;
    // Reset values before any clock edge.
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_psel",      32'(psel),      32'd0);
    chk("rst_penable",   32'(penable),   32'd0);
    chk("rst_pwrite",    32'(pwrite),    32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_timeout",   32'(timeout_o), 32'd0);
    chk("rst_paddr",     32'(paddr),     32'd0);
    chk("rst_pwdata",    pwdata,         32'd0);
    chk("rst_pstrb",     32'(pstrb),     32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    cycle(); cycle();
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // Directed write then read-back, ID read, error read.
    run_txn(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 0, lat, rd, er);
    chk("wr_latency", lat, 32'd3);
    chk("wr_rdata", rd, 32'h0);
    chk("wr_err", 32'(er), 32'd0);
    run_txn(1'b0, 12'h004, 32'h0, 4'hF, 0, 0, lat, rd, er);
    chk("rd_latency", lat, 32'd3);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(er), 32'd0);
    run_txn(1'b0, 12'hFC4, 32'h0, 4'h0, 0, 0, lat, rd, er);
    chk("id_data", rd, 32'h0000003F);
    run_txn(1'b0, 12'h100, 32'h0, 4'h0, 0, 0, lat, rd, er);
    chk("bad_addr_err", 32'(er), 32'd1);

    // Wait states and delayed response consumption.
    run_txn(1'b1, 12'h010, 32'h12345678, 4'h5, 3, 2, lat, rd, er);
    chk("wait_latency", lat, 32'd6);
    run_txn(1'b0, 12'h010, 32'h0, 4'hF, 1, 1, lat, rd, er);
    chk("strb_merge", rd, 32'h00340078);
    idle(1);

    // Reset during ACCESS aborts with no response.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h008; cmd_wdata = 32'hA5A5A5A5; cmd_strb = 4'hF;
    set_idle_exp();
    cycle();
    cmd_valid = 1'b0; pready = 1'b0;
    e_cmd_ready = 1'b0; e_psel = 1'b1; e_pen = 1'b0;
    e_paddr = 12'h008; e_pwrite = 1'b1; e_pwdata = 32'hA5A5A5A5; e_pstrb = 4'hF;
    cycle();
    chk_en = 1'b0;
    chk("pre_rst_penable", 32'(penable), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_psel",      32'(psel),      32'd0);
    chk("midrst_penable",   32'(penable),   32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    cycle();
    rst = 1'b0;
    e_rdata = '0; e_err = 1'b0;
    set_idle_exp();
    chk_en = 1'b1;
    idle(3);
    run_txn(1'b0, 12'h008, 32'h0, 4'h0, 0, 0, lat, rd, er);
    chk("post_rst_latency", lat, 32'd3);
    chk("post_rst_data", rd, 32'h0);

`ifdef APB_MST_TIMEOUT_EN
    run_txn(1'b0, 12'h020, 32'h0, 4'h0, TMO + 5, 0, lat, rd, er);
    chk("tmo_latency", lat, 32'd18);
    chk("tmo_err", 32'(er), 32'd1);
    chk("tmo_rdata", rd, 32'h0);
`endif

    // Randomized traffic.
    for (int unsigned i = 0; i < 80; i++) begin
      run_txn(1'($urandom), rand_addr(), $urandom, 4'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 3), lat, rd, er);
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
